// File: rtl/clock_pkg.sv
// Shared timing defaults and channel FSM state encoding for the button front end.
package clock_pkg;

    // Defaults for a 50 MHz system clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT      = 1_000_000;   // 20 ms
    localparam int unsigned REPEAT_DELAY_CYCLES_DEFAULT  = 25_000_000;  // 500 ms
    localparam int unsigned REPEAT_PERIOD_CYCLES_DEFAULT = 10_000_000;  // 200 ms

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FIRE      = 2'd1,
        ST_HOLD_WAIT = 2'd2,
        ST_REPEAT    = 2'd3
    } chan_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchronizer, debouncer and press/auto-repeat FSM.
// The fire output is combinational; the top level registers it into the pulse.
module button_channel
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEFAULT,
    parameter bit          ACTIVE_LOW           = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic inhibit,
    output logic level,
    output logic fire
);

    localparam int unsigned DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_W = cnt_width(max_u(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

    // Raw pin value when the button is not pressed.
    localparam logic RELEASED_RAW = ACTIVE_LOW;

    logic              sync1_q, sync2_q;
    logic              sync_level;
    logic              db_q;
    logic [DB_W-1:0]   db_cnt_q;
    chan_state_e       state_q, state_d;
    logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;

    // Two-flop synchronizer, held at the released level in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RELEASED_RAW;
            sync2_q <= RELEASED_RAW;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign sync_level = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q     <= 1'b0;
            db_cnt_q <= '0;
        end else if (sync_level != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_q     <= sync_level;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign level = db_q;

    // FSM state and repeat counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Next state, repeat counter and fire request.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        fire      = 1'b0;
        if (!db_q) begin
            // Release (or never pressed): back to idle, no pulse.
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
        end else if (inhibit) begin
            // Both buttons held: park in HOLD_WAIT with the delay restarted, so the
            // survivor of a double press waits a full repeat delay before pulsing.
            state_d   = ST_HOLD_WAIT;
            rpt_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Debounced level high while idle means it has just risen.
                    state_d = ST_FIRE;
                end
                ST_FIRE: begin
                    fire      = 1'b1;
                    state_d   = ST_HOLD_WAIT;
                    rpt_cnt_d = '0;
                end
                ST_HOLD_WAIT: begin
                    if (rpt_cnt_q == DELAY_LAST) begin
                        fire      = 1'b1;
                        state_d   = ST_REPEAT;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (rpt_cnt_q == PERIOD_LAST) begin
                        fire      = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Hour inc/dec button conditioner: two debounced auto-repeat channels with
// double-press suppression and registered, mutually exclusive command pulses.
module button_conditioner
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEFAULT,
    parameter bit          ACTIVE_LOW           = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_held,
    output logic dec_held
);

    logic inc_level, dec_level;
    logic inc_fire, dec_fire;
    logic both_held;
    logic inc_pulse_q, dec_pulse_q;

    assign both_held = inc_level & dec_level;

    button_channel #(
        .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
        .ACTIVE_LOW           (ACTIVE_LOW)
    ) u_inc (
        .clk     (clk),
        .reset   (reset),
        .raw     (btn_inc_raw),
        .inhibit (both_held),
        .level   (inc_level),
        .fire    (inc_fire)
    );

    button_channel #(
        .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
        .ACTIVE_LOW           (ACTIVE_LOW)
    ) u_dec (
        .clk     (clk),
        .reset   (reset),
        .raw     (btn_dec_raw),
        .inhibit (both_held),
        .level   (dec_level),
        .fire    (dec_fire)
    );

    // Register command pulses; block on double press, never back-to-back,
    // and give inc priority so the two can never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
        end else begin
            inc_pulse_q <= inc_fire & ~both_held & ~inc_pulse_q;
            dec_pulse_q <= dec_fire & ~both_held & ~inc_fire & ~dec_pulse_q;
        end
    end

    assign inc_pulse = inc_pulse_q;
    assign dec_pulse = dec_pulse_q;
    assign inc_held  = inc_level;
    assign dec_held  = dec_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short timing constants.
// Stimulus pushes expected pulse cycles; a negedge monitor pops and compares.
module tb_button_conditioner;

    localparam int unsigned DB  = 4;
    localparam int unsigned DLY = 20;
    localparam int unsigned PER = 8;
    // Press driven at cycle n -> first pulse at n + 1 (sampling edge) + DB + 3.
    localparam int FIRST = 1 + DB + 3;
    // Release driven at cycle r -> debounced level falls at r + DB + 2.
    localparam int FALL = DB + 2;

    logic clk = 1'b0;
    logic reset;
    logic btn_inc_raw, btn_dec_raw;
    logic inc_pulse, dec_pulse, inc_held, dec_held;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int at;
        bit is_dec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    button_conditioner #(
        .DEBOUNCE_CYCLES      (DB),
        .REPEAT_DELAY_CYCLES  (DLY),
        .REPEAT_PERIOD_CYCLES (PER),
        .ACTIVE_LOW           (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_inc_raw (btn_inc_raw),
        .btn_dec_raw (btn_dec_raw),
        .inc_pulse   (inc_pulse),
        .dec_pulse   (dec_pulse),
        .inc_held    (inc_held),
        .dec_held    (dec_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input bit is_dec);
        exp_t e;
        e.at     = at;
        e.is_dec = is_dec;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the scoreboard; overdue entries fail.
    always @(negedge clk) begin
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed pulse: got none, required %s pulse at cycle %0d",
                         mon_e.is_dec ? "dec" : "inc", mon_e.at);
            end
            if (inc_pulse || dec_pulse) begin
                check("pulse exclusivity", int'(inc_pulse & dec_pulse), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected pulse: got inc=%0b dec=%0b at cycle %0d, required none",
                             inc_pulse, dec_pulse, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse cycle", cyc, mon_e.at);
                    check("pulse is dec", int'(dec_pulse), int'(mon_e.is_dec));
                end
            end
        end
    end

    initial begin
        int n;
        int m;

        reset       = 1'b1;
        btn_inc_raw = 1'b1;
        btn_dec_raw = 1'b1;
        wait_cycles(3);
        check("reset inc_pulse", int'(inc_pulse), 0);
        check("reset dec_pulse", int'(dec_pulse), 0);
        check("reset inc_held", int'(inc_held), 0);
        check("reset dec_held", int'(dec_held), 0);
        reset = 1'b0;
        wait_cycles(10);
        check("idle inc_held", int'(inc_held), 0);

        // Clean press held 10 cycles: one pulse, no repeat.
        n = cyc;
        btn_inc_raw = 1'b0;
        expect_pulse(n + FIRST, 1'b0);
        wait_cycles(9);
        check("clean inc_held", int'(inc_held), 1);
        check("clean dec_held", int'(dec_held), 0);
        wait_cycles(1);
        btn_inc_raw = 1'b1;
        wait_cycles(15);
        check("clean release inc_held", int'(inc_held), 0);

        // Bounce: six 2-cycle segments, then 6 stable low cycles.
        n = cyc;
        for (int i = 0; i < 6; i++) begin
            btn_inc_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_cycles(2);
        end
        btn_inc_raw = 1'b0;
        expect_pulse(n + 12 + FIRST, 1'b0);
        wait_cycles(6);
        btn_inc_raw = 1'b1;
        wait_cycles(15);
        check("bounce release inc_held", int'(inc_held), 0);

        // Auto-repeat: dec held 60 cycles; repeats until its level falls at n+60+FALL.
        n = cyc;
        btn_dec_raw = 1'b0;
        expect_pulse(n + FIRST, 1'b1);
        for (int t = n + FIRST + DLY; t <= n + 60 + FALL; t += PER) expect_pulse(t, 1'b1);
        wait_cycles(30);
        check("repeat dec_held", int'(dec_held), 1);
        wait_cycles(30);
        btn_dec_raw = 1'b1;
        wait_cycles(20);
        check("repeat release dec_held", int'(dec_held), 0);

        // Double press: inc, then dec 5 cycles later; release dec at n+45, inc at n+75.
        n = cyc;
        btn_inc_raw = 1'b0;
        expect_pulse(n + FIRST, 1'b0);
        wait_cycles(5);
        btn_dec_raw = 1'b0;
        wait_cycles(20);
        check("double inc_held", int'(inc_held), 1);
        check("double dec_held", int'(dec_held), 1);
        wait_cycles(20);
        btn_dec_raw = 1'b1;
        expect_pulse(n + 45 + FALL + DLY, 1'b0);
        expect_pulse(n + 45 + FALL + DLY + PER, 1'b0);
        wait_cycles(30);
        check("double survivor inc_held", int'(inc_held), 1);
        check("double released dec_held", int'(dec_held), 0);
        btn_inc_raw = 1'b1;
        wait_cycles(20);
        check("double release inc_held", int'(inc_held), 0);

        // Reset during repeat with the button still held.
        n = cyc;
        btn_inc_raw = 1'b0;
        expect_pulse(n + FIRST, 1'b0);
        expect_pulse(n + FIRST + DLY, 1'b0);
        expect_pulse(n + FIRST + DLY + PER, 1'b0);
        wait_cycles(40);
        reset = 1'b1;
        #1;
        check("midreset inc_pulse", int'(inc_pulse), 0);
        check("midreset dec_pulse", int'(dec_pulse), 0);
        check("midreset inc_held", int'(inc_held), 0);
        check("midreset dec_held", int'(dec_held), 0);
        wait_cycles(3);
        reset = 1'b0;
        m = cyc;
        expect_pulse(m + FIRST, 1'b0);
        wait_cycles(12);
        check("post-reset inc_held", int'(inc_held), 1);
        btn_inc_raw = 1'b1;
        wait_cycles(20);
        check("post-reset release inc_held", int'(inc_held), 0);

        wait_cycles(5);
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL pending pulse: got none, required %s pulse at cycle %0d",
                     mon_e.is_dec ? "dec" : "inc", mon_e.at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
